// File: rtl/expr_pkg.sv
// rtl/expr_pkg.sv - shared state encoding, ASCII constants and reset values for expr_eval
package expr_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OPND = 2'd1;
    localparam logic [1:0] NUM  = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    localparam logic [7:0] CH_NUL    = 8'h00;
    localparam logic [7:0] CH_PLUS   = 8'h2B;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_LPAREN = 8'h28;
    localparam logic [7:0] CH_RPAREN = 8'h29;
    localparam logic [7:0] CH_ZERO   = 8'h30;
    localparam logic [7:0] CH_NINE   = 8'h39;

    localparam int SUM_RST  = 0;
    localparam int PROD_RST = 1;
    localparam int NUM_RST  = 0;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_ZERO) && (c <= CH_NINE);
    endfunction

endpackage

// File: rtl/expr_mac.sv
// rtl/expr_mac.sv - sum + prod*num combine with overflow detection, also exposes the bare product
module expr_mac #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] sum,
    input  logic [WIDTH-1:0] prod,
    input  logic [WIDTH-1:0] num,
    output logic [WIDTH-1:0] product,
    output logic             product_ovf,
    output logic [WIDTH-1:0] result,
    output logic             result_ovf
);

    logic [2*WIDTH-1:0] full_prod;
    logic [WIDTH:0]     full_sum;

    assign full_prod   = {{WIDTH{1'b0}}, prod} * {{WIDTH{1'b0}}, num};
    assign full_sum    = {1'b0, sum} + {1'b0, full_prod[WIDTH-1:0]};
    assign product     = full_prod[WIDTH-1:0];
    assign product_ovf = |full_prod[2*WIDTH-1:WIDTH];
    assign result      = full_sum[WIDTH-1:0];
    assign result_ovf  = product_ovf | full_sum[WIDTH];

endmodule

// File: rtl/expr_eval.sv
// rtl/expr_eval.sv - streaming ASCII +,* expression evaluator (one char per clock, NUL terminates)
// Optional one-level parentheses enabled by defining EXPR_EVAL_PAREN_EN.
module expr_eval
    import expr_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [7:0]       in,
    output logic [WIDTH-1:0] value,
    output logic             done,
    output logic             err,
    output logic             ovf,
    output logic             busy
);

    state_t           state, state_n;
    logic [WIDTH-1:0] sum, sum_n, prod, prod_n, num, num_n, value_n;
    logic             ovf_acc, ovf_acc_n, err_n, ovf_n, done_n, finish;
    logic             at_top;
    logic [WIDTH+3:0] num10;
    logic [WIDTH-1:0] mac_product, mac_result;
    logic             mac_product_ovf, mac_result_ovf;

`ifdef EXPR_EVAL_PAREN_EN
    logic [WIDTH-1:0] save_sum, save_sum_n, save_prod, save_prod_n;
    logic             depth, depth_n;
    assign at_top = ~depth;
`else
    assign at_top = 1'b1;
`endif

    expr_mac #(.WIDTH(WIDTH)) u_mac (
        .sum         (sum),
        .prod        (prod),
        .num         (num),
        .product     (mac_product),
        .product_ovf (mac_product_ovf),
        .result      (mac_result),
        .result_ovf  (mac_result_ovf)
    );

    // num*10 + digit evaluated with 4 guard bits so overflow is visible
    assign num10 = {1'b0, num, 3'b000} + {3'b000, num, 1'b0} + {{WIDTH{1'b0}}, in[3:0]};
    assign busy  = (state != IDLE);

    always_comb begin
        state_n   = state;
        sum_n     = sum;
        prod_n    = prod;
        num_n     = num;
        ovf_acc_n = ovf_acc;
        value_n   = value;
        err_n     = err;
        ovf_n     = ovf;
        done_n    = 1'b0;
        finish    = 1'b0;
`ifdef EXPR_EVAL_PAREN_EN
        save_sum_n  = save_sum;
        save_prod_n = save_prod;
        depth_n     = depth;
`endif
        if (state == ERR) begin
            if (in == CH_NUL) begin
                value_n = '0;
                err_n   = 1'b1;
                ovf_n   = ovf_acc;
                done_n  = 1'b1;
                finish  = 1'b1;
            end
        end else if (is_digit(in)) begin
            num_n     = num10[WIDTH-1:0];
            ovf_acc_n = ovf_acc | (|num10[WIDTH+3:WIDTH]);
            state_n   = NUM;
        end else if (in == CH_PLUS) begin
            if (state == NUM) begin
                sum_n     = mac_result;
                prod_n    = WIDTH'(PROD_RST);
                num_n     = WIDTH'(NUM_RST);
                ovf_acc_n = ovf_acc | mac_result_ovf;
                state_n   = OPND;
            end else begin
                state_n = ERR;
            end
        end else if (in == CH_STAR) begin
            if (state == NUM) begin
                prod_n    = mac_product;
                num_n     = WIDTH'(NUM_RST);
                ovf_acc_n = ovf_acc | mac_product_ovf;
                state_n   = OPND;
            end else begin
                state_n = ERR;
            end
        end else if (in == CH_NUL) begin
            if (state == NUM && at_top) begin
                value_n = mac_result;
                err_n   = 1'b0;
                ovf_n   = ovf_acc | mac_result_ovf;
                done_n  = 1'b1;
                finish  = 1'b1;
            end else if (state != IDLE) begin
                value_n = '0;
                err_n   = 1'b1;
                ovf_n   = ovf_acc;
                done_n  = 1'b1;
                finish  = 1'b1;
            end
`ifdef EXPR_EVAL_PAREN_EN
        end else if (in == CH_LPAREN) begin
            if (state != NUM && !depth) begin
                save_sum_n  = sum;
                save_prod_n = prod;
                depth_n     = 1'b1;
                sum_n       = WIDTH'(SUM_RST);
                prod_n      = WIDTH'(PROD_RST);
                num_n       = WIDTH'(NUM_RST);
                state_n     = OPND;
            end else begin
                state_n = ERR;
            end
        end else if (in == CH_RPAREN) begin
            if (state == NUM && depth) begin
                num_n     = mac_result;
                ovf_acc_n = ovf_acc | mac_result_ovf;
                sum_n     = save_sum;
                prod_n    = save_prod;
                depth_n   = 1'b0;
            end else begin
                state_n = ERR;
            end
`endif
        end else begin
            state_n = ERR;
        end

        // A completed expression leaves the working registers ready for the next one
        if (finish) begin
            state_n   = IDLE;
            sum_n     = WIDTH'(SUM_RST);
            prod_n    = WIDTH'(PROD_RST);
            num_n     = WIDTH'(NUM_RST);
            ovf_acc_n = 1'b0;
`ifdef EXPR_EVAL_PAREN_EN
            depth_n   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= IDLE;
            sum     <= WIDTH'(SUM_RST);
            prod    <= WIDTH'(PROD_RST);
            num     <= WIDTH'(NUM_RST);
            ovf_acc <= 1'b0;
            value   <= '0;
            err     <= 1'b0;
            ovf     <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            sum     <= sum_n;
            prod    <= prod_n;
            num     <= num_n;
            ovf_acc <= ovf_acc_n;
            value   <= value_n;
            err     <= err_n;
            ovf     <= ovf_n;
            done    <= done_n;
        end
    end

`ifdef EXPR_EVAL_PAREN_EN
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            save_sum  <= WIDTH'(SUM_RST);
            save_prod <= WIDTH'(PROD_RST);
            depth     <= 1'b0;
        end else begin
            save_sum  <= save_sum_n;
            save_prod <= save_prod_n;
            depth     <= depth_n;
        end
    end
`endif

endmodule
